localbus_arbiter: RTL and testbench

- Two-master arbiter placed in front of `localbus`.
- Master 0 is the `top_core` data port. Master 1 is a secondary bus master, such as a boot loader or DMA engine that fills data RAM or the VGA framebuffer.
- Grants the single localbus slave port one transfer per cycle, using round-robin with an optional lock, and routes read data back to the issuing master after the fixed localbus read latency.

---
 rtl/localbus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_localbus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/localbus_arbiter.sv
// localbus_arbiter: two-master round-robin arbiter with grant lock in front of localbus.
// Read data is steered back to the issuing master after the fixed slave read latency.
// Build macro LBARB_LOCK_TIMEOUT_EN bounds consecutive locked grants to LOCK_MAX
// when the other master is waiting; without it locks are honoured indefinitely.
module localbus_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned LOCK_MAX = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_req,
    input  logic            m0_lock,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [3:0]      m0_we,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic            m1_lock,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [3:0]      m1_we,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] qin,
    output logic [3:0]      we,
    input  logic [XLEN-1:0] qout,
    output logic            lock_tmo
);

    if (RD_LAT < 1 || RD_LAT > 4 || LOCK_MAX < 1) begin : g_param_check
        $error("localbus_arbiter: RD_LAT must be 1..4 and LOCK_MAX must be >= 1");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              tmo_hit;

    // Read-return pipe: one slot per cycle of slave latency, id 1 means master 1.
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0] pipe_id_q, pipe_id_d;
    logic              rd_push;
    logic              tail_vld;
    logic              tail_id;

    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [XLEN-1:0]   m0_rdata_q, m0_rdata_d;
    logic [XLEN-1:0]   m1_rdata_q, m1_rdata_d;

`ifdef LBARB_LOCK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(LOCK_MAX - 1);

    logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
    logic              lock_tmo_q, lock_tmo_d;
    logic              own_act;
    logic              forced;

    assign tmo_hit = (lock_cnt_q == CntMax);
    // Grant served from an owned state this cycle.
    assign own_act = rst_n && ((state_q == StOwn0 && m0_req) || (state_q == StOwn1 && m1_req));
    // Owner loses the grant to a waiting master once the lock budget is spent.
    assign forced  = own_act && tmo_hit && ((state_q == StOwn0) ? m1_req : m0_req);
    assign lock_tmo = lock_tmo_q;

    // Lock budget counter: counts owned grants, saturating; any other cycle restarts it.
    always_comb begin
        lock_cnt_d = '0;
        lock_tmo_d = lock_tmo_q | forced;
        if (own_act && !forced) begin
            lock_cnt_d = tmo_hit ? lock_cnt_q : lock_cnt_q + 1'b1;
        end
    end

    // Lock budget state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_tmo_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_tmo_q <= lock_tmo_d;
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign lock_tmo = 1'b0;
`endif

    // Zero-latency grant decision; nothing is granted while reset is asserted.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (state_q == StOwn0 && m0_req) begin
                if (tmo_hit && m1_req) m1_gnt = 1'b1;
                else                   m0_gnt = 1'b1;
            end else if (state_q == StOwn1 && m1_req) begin
                if (tmo_hit && m0_req) m0_gnt = 1'b1;
                else                   m1_gnt = 1'b1;
            end else if (m0_req && m1_req) begin
                // Tie goes to the master that did not win last time.
                m0_gnt = rr_last_q;
                m1_gnt = ~rr_last_q;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Next arbitration state, slave-port mux and read-pipe push.
    always_comb begin
        state_d   = StIdle;
        rr_last_d = rr_last_q;
        addr      = '0;
        qin       = '0;
        we        = 4'h0;
        rd_push   = 1'b0;
        if (m0_gnt) begin
            rr_last_d = 1'b0;
            state_d   = m0_lock ? StOwn0 : StIdle;
            addr      = m0_addr;
            qin       = m0_wdata;
            we        = m0_we;
            rd_push   = (m0_we == 4'h0);
        end else if (m1_gnt) begin
            rr_last_d = 1'b1;
            state_d   = m1_lock ? StOwn1 : StIdle;
            addr      = m1_addr;
            qin       = m1_wdata;
            we        = m1_we;
            rd_push   = (m1_we == 4'h0);
        end
    end

    if (RD_LAT == 1) begin : g_pipe_one
        assign pipe_vld_d = rd_push;
        assign pipe_id_d  = m1_gnt;
    end else begin : g_pipe_deep
        assign pipe_vld_d = {pipe_vld_q[RD_LAT-2:0], rd_push};
        assign pipe_id_d  = {pipe_id_q[RD_LAT-2:0], m1_gnt};
    end

    assign tail_vld = pipe_vld_q[RD_LAT-1];
    assign tail_id  = pipe_id_q[RD_LAT-1];

    // At the pipe tail qout belongs to the recorded master; capture it there.
    always_comb begin
        m0_rvalid_d = tail_vld && !tail_id;
        m1_rvalid_d = tail_vld && tail_id;
        m0_rdata_d  = m0_rvalid_d ? qout : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? qout : m1_rdata_q;
    end

    // Arbitration and read-return state; reset drops any in-flight returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_last_q   <= 1'b1;
            pipe_vld_q  <= '0;
            pipe_id_q   <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_id_q   <= pipe_id_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_localbus_arbiter.sv
// tb_localbus_arbiter: directed vector table plus random traffic against a reference model.
// Two arbiters (read latency 1 and 3) share the same master stimulus.
module tb_localbus_arbiter;

    localparam int unsigned LockMax = 4;
    localparam int NumVec = 39;
`ifdef LBARB_LOCK_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    typedef struct {
        bit          rst;
        bit          r0;
        bit          l0;
        logic [3:0]  we0;
        logic [31:0] a0;
        logic [31:0] w0;
        bit          r1;
        bit          l1;
        logic [3:0]  we1;
        logic [31:0] a1;
        logic [31:0] w1;
        bit          g0;
        bit          g1;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_we, m1_we;

    logic        a_g0, a_g1, a_rv0, a_rv1, a_tmo;
    logic [31:0] a_rd0, a_rd1, a_addr, a_qin, a_qout;
    logic [3:0]  a_we;
    logic        b_g0, b_g1, b_rv0, b_rv1, b_tmo;
    logic [31:0] b_rd0, b_rd1, b_addr, b_qin, b_qout;
    logic [3:0]  b_we;

    always #5 clk = ~clk;

    localbus_arbiter #(.XLEN(32), .RD_LAT(1), .LOCK_MAX(LockMax)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_we(m0_we), .m0_gnt(a_g0), .m0_rvalid(a_rv0), .m0_rdata(a_rd0),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_we(m1_we), .m1_gnt(a_g1), .m1_rvalid(a_rv1), .m1_rdata(a_rd1),
        .addr(a_addr), .qin(a_qin), .we(a_we), .qout(a_qout), .lock_tmo(a_tmo)
    );

    localbus_arbiter #(.XLEN(32), .RD_LAT(3), .LOCK_MAX(LockMax)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_we(m0_we), .m0_gnt(b_g0), .m0_rvalid(b_rv0), .m0_rdata(b_rd0),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_we(m1_we), .m1_gnt(b_g1), .m1_rvalid(b_rv1), .m1_rdata(b_rd1),
        .addr(b_addr), .qin(b_qin), .we(b_we), .qout(b_qout), .lock_tmo(b_tmo)
    );

    // localbus stub: read data is a fixed function of the address, delayed by the latency.
    function automatic logic [31:0] stub_data(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    logic [31:0] a_hist;
    logic [31:0] b_hist [3];
    always @(posedge clk) begin
        a_hist    <= a_addr;
        b_hist[0] <= b_addr;
        b_hist[1] <= b_hist[0];
        b_hist[2] <= b_hist[1];
    end
    assign a_qout = stub_data(a_hist);
    assign b_qout = stub_data(b_hist[2]);

    // Reference model state.
    int          mdl_owner;
    int          mdl_rr;
    int          mdl_run;
    bit          mdl_tmo;
    int          cyc;
    ret_t        q_a[$];
    ret_t        q_b[$];
    logic [31:0] exp_rd [2][2];
    bit          exp_rv [2][2];
    int          e_g;
    logic [31:0] e_addr, e_qin;
    logic [3:0]  e_we;
    int          n_chk, n_pass;
    vec_t        tbl [NumVec];

    function automatic vec_t mk(input bit rst, input bit r0, input bit l0, input logic [3:0] we0,
                                input logic [31:0] a0, input bit r1, input bit l1,
                                input logic [3:0] we1, input logic [31:0] a1,
                                input logic [31:0] w1, input bit g0, input bit g1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.l0 = l0; v.we0 = we0; v.a0 = a0; v.w0 = ~a0;
        v.r1 = r1; v.l1 = l1; v.we1 = we1; v.a1 = a1; v.w1 = w1; v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    function automatic void chk(input int k, input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL dut%0d %s cyc=%0d got=%h expected=%h", k, name, cyc, act, exp);
        else
            n_pass++;
    endfunction

    // Grant decision from the arbitration rules; -1 means no grant.
    function automatic int mdl_grant(input vec_t v, output bit forced, output bit from_own);
        bit req [2];
        req[0] = v.r0;
        req[1] = v.r1;
        forced   = 1'b0;
        from_own = 1'b0;
        if (!v.rst) return -1;
        if (mdl_owner >= 0 && req[mdl_owner]) begin
            from_own = 1'b1;
            if (TmoEn && mdl_run >= int'(LockMax) - 1 && req[1 - mdl_owner]) begin
                forced = 1'b1;
                return 1 - mdl_owner;
            end
            return mdl_owner;
        end
        if (req[0] && req[1]) return 1 - mdl_rr;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic mdl_reset();
        mdl_owner = -1;
        mdl_rr    = 1;
        mdl_run   = 0;
        mdl_tmo   = 1'b0;
        q_a.delete();
        q_b.delete();
        for (int k = 0; k < 2; k++) begin
            exp_rd[k][0] = '0;
            exp_rd[k][1] = '0;
        end
    endtask

    task automatic chk_inst(input int k, input logic g0, input logic g1, input logic [31:0] ad,
                            input logic [31:0] qi, input logic [3:0] w, input logic rv0,
                            input logic rv1, input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic tmo);
        chk(k, "m0_gnt", 32'(g0), 32'(e_g == 0));
        chk(k, "m1_gnt", 32'(g1), 32'(e_g == 1));
        chk(k, "addr", ad, e_addr);
        chk(k, "qin", qi, e_qin);
        chk(k, "we", 32'(w), 32'(e_we));
        chk(k, "m0_rvalid", 32'(rv0), 32'(exp_rv[k][0]));
        chk(k, "m1_rvalid", 32'(rv1), 32'(exp_rv[k][1]));
        chk(k, "m0_rdata", rd0, exp_rd[k][0]);
        chk(k, "m1_rdata", rd1, exp_rd[k][1]);
        chk(k, "lock_tmo", 32'(tmo), 32'(mdl_tmo));
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tbl);
        bit          forced, from_own, lk;
        logic [3:0]  w;
        logic [31:0] ad, wd;
        ret_t        r;
        rst_n = v.rst;
        m0_req = v.r0; m0_lock = v.l0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.w0;
        m1_req = v.r1; m1_lock = v.l1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.w1;
        #4;
        e_g = mdl_grant(v, forced, from_own);
        lk = (e_g == 0) ? v.l0 : v.l1;
        w  = (e_g == 0) ? v.we0 : v.we1;
        ad = (e_g == 0) ? v.a0 : v.a1;
        wd = (e_g == 0) ? v.w0 : v.w1;
        e_addr = (e_g >= 0) ? ad : '0;
        e_qin  = (e_g >= 0) ? wd : '0;
        e_we   = (e_g >= 0) ? w : 4'h0;
        for (int k = 0; k < 2; k++) begin
            exp_rv[k][0] = 1'b0;
            exp_rv[k][1] = 1'b0;
        end
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
            r = q_a.pop_front();
            exp_rv[0][r.id] = 1'b1;
            exp_rd[0][r.id] = r.data;
        end
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
            r = q_b.pop_front();
            exp_rv[1][r.id] = 1'b1;
            exp_rd[1][r.id] = r.data;
        end
        chk_inst(0, a_g0, a_g1, a_addr, a_qin, a_we, a_rv0, a_rv1, a_rd0, a_rd1, a_tmo);
        chk_inst(1, b_g0, b_g1, b_addr, b_qin, b_we, b_rv0, b_rv1, b_rd0, b_rd1, b_tmo);
        if (use_tbl) begin
            chk(0, "tbl_m0_gnt", 32'(a_g0), 32'(v.g0));
            chk(0, "tbl_m1_gnt", 32'(a_g1), 32'(v.g1));
            chk(1, "tbl_m0_gnt", 32'(b_g0), 32'(v.g0));
            chk(1, "tbl_m1_gnt", 32'(b_g1), 32'(v.g1));
        end
        @(posedge clk);
        #1;
        if (!v.rst) begin
            mdl_reset();
        end else if (e_g >= 0) begin
            mdl_rr    = e_g;
            mdl_owner = lk ? e_g : -1;
            if (forced) begin
                mdl_run = 0;
                mdl_tmo = 1'b1;
            end else if (from_own) begin
                mdl_run++;
            end else begin
                mdl_run = 0;
            end
            if (w == 4'h0) begin
                r.id   = e_g;
                r.data = stub_data(ad);
                r.due  = cyc + 2;
                q_a.push_back(r);
                r.due  = cyc + 4;
                q_b.push_back(r);
            end
        end else begin
            mdl_owner = -1;
            mdl_run   = 0;
        end
        cyc++;
    endtask

    initial begin
        vec_t v;
        vec_t idle;
        bit   hit;
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        idle = mk(1, 0, 0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);

        // Reset with both requesting, then continuous ties alternating from m0.
        tbl[0] = mk(0, 1, 0, 4'h0, 32'h100, 1, 0, 4'h0, 32'h104, 32'h0, 0, 0);
        tbl[1] = mk(0, 0, 0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++)
            tbl[2 + i] = mk(1, 1, 0, 4'h0, 32'h100 + 32'(8 * i), 1, 0, 4'h0,
                            32'h104 + 32'(8 * i), 32'h0, (i % 2) == 0, (i % 2) == 1);
        tbl[6] = idle;
        // Partial write from m1.
        tbl[7] = mk(1, 0, 0, 4'h0, 32'h0, 1, 0, 4'b0011, 32'h2000, 32'h1234, 0, 1);
        tbl[8] = idle;
        // m1 holds a read lock for 10 cycles against a waiting m0.
        tbl[9] = mk(1, 0, 0, 4'h0, 32'h0, 1, 1, 4'h0, 32'h3000, 32'h0, 0, 1);
        for (int j = 1; j <= 9; j++) begin
            hit = TmoEn && (j == 4 || j == 9);
            tbl[9 + j] = mk(1, 1, 0, 4'h0, 32'h3100 + 32'(4 * j), 1, 1, 4'h0,
                            32'h3000 + 32'(4 * j), 32'h0, hit, !hit);
        end
        tbl[19] = mk(1, 1, 0, 4'h0, 32'h3200, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        tbl[20] = idle;
        // m1 locks on writes indefinitely against a waiting m0.
        tbl[21] = mk(1, 0, 0, 4'h0, 32'h0, 1, 1, 4'hF, 32'h4000, 32'h55, 0, 1);
        for (int j = 1; j <= 9; j++) begin
            hit = TmoEn && (j == 4 || j == 9);
            tbl[21 + j] = mk(1, 1, 0, 4'h0, 32'h4100 + 32'(4 * j), 1, 1, 4'hF,
                             32'h4000 + 32'(4 * j), 32'(j), hit, !hit);
        end
        tbl[31] = idle;
        // Reset while a read is in flight; first post-reset tie goes to m0.
        tbl[32] = mk(1, 1, 0, 4'h0, 32'h500, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        tbl[33] = mk(0, 1, 0, 4'h0, 32'h504, 1, 0, 4'h0, 32'h508, 32'h0, 0, 0);
        tbl[34] = mk(1, 1, 0, 4'h0, 32'h600, 1, 0, 4'h0, 32'h604, 32'h0, 1, 0);
        for (int i = 35; i < NumVec; i++) tbl[i] = idle;

        rst_n = 1'b0;
        m0_req = 1'b0; m0_lock = 1'b0; m0_we = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 4'h0; m1_addr = '0; m1_wdata = '0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NumVec; i++) run_cycle(tbl[i], 1'b1);

        for (int i = 0; i < 400; i++) begin
            v.rst = ($urandom_range(0, 39) != 0);
            v.r0  = ($urandom_range(0, 9) < 6);
            v.l0  = ($urandom_range(0, 3) == 0);
            v.we0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            v.a0  = $urandom;
            v.w0  = $urandom;
            v.r1  = ($urandom_range(0, 9) < 6);
            v.l1  = ($urandom_range(0, 3) == 0);
            v.we1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            v.a1  = $urandom;
            v.w1  = $urandom;
            v.g0  = 1'b0;
            v.g1  = 1'b0;
            run_cycle(v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
